// File: rtl/cnt_hour.sv
// -----------------------------------------------------------------------------
// cnt_hour -- hour stage of a digital clock.
//
// Counts hours 0..23, advanced by the rising edge of the minute-stage carry
// while running, or by the rising edge of a manual increment while the user
// is setting the time. Produces a registered BCD display in either 24-hour
// or 12-hour form, a PM flag, and a one-cycle carry into the day stage.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous reset, active low
//   carry_in   minute-stage carry level (rising edge = one hour elapsed)
//   mode_24    display mode: 1 = 24-hour, 0 = 12-hour
//   set_en     level, 1 requests hour-set mode
//   set_inc    manual increment request (rising edge = +1 hour in set mode)
//   hour24     current hour, 0..23
//   disp_tens  BCD tens digit of the displayed hour (one cycle behind)
//   disp_ones  BCD ones digit of the displayed hour (one cycle behind)
//   pm         1 when hour24 >= 12, regardless of display mode
//   day_clk    one-cycle carry to the day stage on the 23 -> 0 rollover
//   setting    1 while in set mode
// -----------------------------------------------------------------------------
module cnt_hour #(
  parameter int unsigned INIT_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       carry_in,
  input  logic       mode_24,
  input  logic       set_en,
  input  logic       set_inc,
  output logic [4:0] hour24,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       pm,
  output logic       day_clk,
  output logic       setting
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam logic [4:0] INIT_H    = 5'(INIT_HOUR);
  localparam logic [3:0] INIT_TENS = 4'(INIT_HOUR / 10);
  localparam logic [3:0] INIT_ONES = 4'(INIT_HOUR % 10);

  state_t     r_state;
  state_t     w_stateNext;
  logic       r_carryD;
  logic       r_incD;
  logic       w_carryEdge;
  logic       w_incEdge;
  logic [4:0] r_hour;
  logic [4:0] w_hourNext;
  logic       r_dayClk;
  logic       w_dayNext;
  logic [4:0] w_dispHour;
  logic [4:0] w_tensSub;
  logic [3:0] w_dispTens;
  logic [3:0] w_dispOnes;
  logic [3:0] r_dispTens;
  logic [3:0] r_dispOnes;

  // Delayed copies for edge detection. They track their inputs even during
  // reset, so a level already high at release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    r_carryD <= carry_in;
    r_incD   <= set_inc;
  end

  assign w_carryEdge = carry_in & ~r_carryD;
  assign w_incEdge   = set_inc & ~r_incD;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and next hour. Edges are always judged by the current state,
  // so an edge landing on a mode change follows the mode being left.
  // The wrap uses >= so a corrupted count can never climb past 23.
  always_comb begin
    w_stateNext = r_state;
    w_hourNext  = r_hour;
    w_dayNext   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (set_en) begin
          w_stateNext = ST_SET;
        end
        if (w_carryEdge) begin
          if (r_hour >= 5'd23) begin
            w_hourNext = 5'd0;
            w_dayNext  = 1'b1;
          end else begin
            w_hourNext = r_hour + 5'd1;
          end
        end
      end
      ST_SET: begin
        if (!set_en) begin
          w_stateNext = ST_RUN;
        end
        if (w_incEdge) begin
          w_hourNext = (r_hour >= 5'd23) ? 5'd0 : r_hour + 5'd1;
        end
      end
      default: begin
        w_stateNext = ST_RUN;
      end
    endcase
  end

  // Display hour: 12-hour mode shows 0 as 12 and folds 13..23 onto 1..11.
  always_comb begin
    w_dispHour = r_hour;
    if (!mode_24) begin
      if (r_hour == 5'd0) begin
        w_dispHour = 5'd12;
      end else if (r_hour > 5'd12) begin
        w_dispHour = r_hour - 5'd12;
      end
    end
  end

  // Binary to BCD for 0..23 only needs a tens digit of 0, 1 or 2.
  always_comb begin
    w_tensSub  = 5'd0;
    w_dispTens = 4'd0;
    if (w_dispHour >= 5'd20) begin
      w_tensSub  = 5'd20;
      w_dispTens = 4'd2;
    end else if (w_dispHour >= 5'd10) begin
      w_tensSub  = 5'd10;
      w_dispTens = 4'd1;
    end
    w_dispOnes = 4'(w_dispHour - w_tensSub);
  end

  // Hour count, day carry and display registers. Reset shows the start hour
  // in 24-hour form whatever the selected mode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hour     <= INIT_H;
      r_dayClk   <= 1'b0;
      r_dispTens <= INIT_TENS;
      r_dispOnes <= INIT_ONES;
    end else begin
      r_hour     <= w_hourNext;
      r_dayClk   <= w_dayNext;
      r_dispTens <= w_dispTens;
      r_dispOnes <= w_dispOnes;
    end
  end

  assign hour24    = r_hour;
  assign disp_tens = r_dispTens;
  assign disp_ones = r_dispOnes;
  assign pm        = (r_hour >= 5'd12);
  assign day_clk   = r_dayClk;
  assign setting   = (r_state == ST_SET);

endmodule

// File: tb/tb_cnt_hour.sv
// -----------------------------------------------------------------------------
// tb_cnt_hour -- directed bench for cnt_hour.
//
// Two instances: dutA starts at hour 0, dutB starts at hour 5. Expected values
// are pushed to a scoreboard queue as stimulus is driven and popped when the
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cnt_hour;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, carryA, modeA, setEnA, incA;
  logic [4:0] hourA;
  logic [3:0] tensA, onesA;
  logic       pmA, dayA, settingA;

  logic       rstB, carryB, modeB, setEnB, incB;
  logic [4:0] hourB;
  logic [3:0] tensB, onesB;
  logic       pmB, dayB, settingB;

  cnt_hour #(.INIT_HOUR(0)) dutA (
    .clk(clk), .rst(rstA), .carry_in(carryA), .mode_24(modeA),
    .set_en(setEnA), .set_inc(incA), .hour24(hourA), .disp_tens(tensA),
    .disp_ones(onesA), .pm(pmA), .day_clk(dayA), .setting(settingA)
  );

  cnt_hour #(.INIT_HOUR(5)) dutB (
    .clk(clk), .rst(rstB), .carry_in(carryB), .mode_24(modeB),
    .set_en(setEnB), .set_inc(incB), .hour24(hourB), .disp_tens(tensB),
    .disp_ones(onesB), .pm(pmB), .day_clk(dayB), .setting(settingB)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int compared   = 0;
  int mismatched = 0;

  // Number of cycles day_clk of dutA has been seen high, sampled before the
  // registers update on each rising edge.
  int dayCountA = 0;
  always @(posedge clk) begin
    if (dayA === 1'b1) dayCountA++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] exp);
    sbItem_t it;
    it.tag = tag;
    it.exp = exp;
    sbQ.push_back(it);
  endtask

  task automatic checkOutput(input logic [7:0] observed);
    sbItem_t it;
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $error("[TB] FAIL sb_empty: observed %0d, nothing expected", observed);
    end else begin
      it = sbQ.pop_front();
      assert (observed === it.exp)
      else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %0d expected %0d", it.tag, observed, it.exp);
      end
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int disp12(input int h);
    return ((h % 12) == 0) ? 12 : (h % 12);
  endfunction

  initial begin
    int dayBase;
    int h;

    rstA = 1'b0; carryA = 1'b0; modeA = 1'b0; setEnA = 1'b0; incA = 1'b0;
    rstB = 1'b0; carryB = 1'b1; modeB = 1'b0; setEnB = 1'b0; incB = 1'b0;

    // Reset of dutA with 12-hour mode selected: display still shows 00.
    step(2);
    applyStimulus("rst_disp24", 8'h00);   checkOutput({tensA, onesA});
    applyStimulus("rst_hour", 8'd0);      checkOutput(8'(hourA));
    applyStimulus("rst_setting", 8'd0);   checkOutput(8'(settingA));
    applyStimulus("rst_day", 8'd0);       checkOutput(8'(dayA));
    applyStimulus("rst_pm", 8'd0);        checkOutput(8'(pmA));

    rstA = 1'b1;
    applyStimulus("post_rst_disp12", 8'h12);
    step(2);
    checkOutput({tensA, onesA});

    // Full day of minute carries: 0..23 then back to 0, one day_clk.
    modeA   = 1'b1;
    dayBase = dayCountA;
    for (int i = 0; i < 24; i++) begin
      carryA = 1'b1;
      applyStimulus("carry_step", 8'((i + 1) % 24));
      step(30);
      checkOutput(8'(hourA));
      carryA = 1'b0;
      step(30);
    end
    applyStimulus("day_once", 8'd1);
    checkOutput(8'(dayCountA - dayBase));

    // Display lags hour24 by one cycle; a long level counts once.
    carryA = 1'b1;
    applyStimulus("lag_hour", 8'd1);
    applyStimulus("lag_disp_old", 8'h00);
    step(1);
    checkOutput(8'(hourA));
    checkOutput({tensA, onesA});
    applyStimulus("lag_disp_new", 8'h01);
    step(1);
    checkOutput({tensA, onesA});
    applyStimulus("level_once", 8'd1);
    step(98);
    checkOutput(8'(hourA));
    carryA = 1'b0;
    step(5);

    // Set mode: concurrent inc and carry pulses give one step each.
    dayBase = dayCountA;
    setEnA  = 1'b1;
    applyStimulus("set_enter", 8'd1);
    step(1);
    checkOutput(8'(settingA));
    for (int i = 0; i < 3; i++) begin
      carryA = 1'b1;
      incA   = 1'b1;
      applyStimulus("set_inc_carry", 8'(2 + i));
      step(3);
      checkOutput(8'(hourA));
      carryA = 1'b0;
      incA   = 1'b0;
      step(3);
    end
    carryA = 1'b1;
    applyStimulus("set_carry_drop", 8'd4);
    step(3);
    checkOutput(8'(hourA));
    carryA = 1'b0;
    step(3);
    for (int i = 0; i < 19; i++) begin
      incA = 1'b1;
      step(2);
      incA = 1'b0;
      step(2);
    end
    applyStimulus("set_reach23", 8'd23);
    checkOutput(8'(hourA));
    incA = 1'b1;
    applyStimulus("set_wrap", 8'd0);
    step(3);
    checkOutput(8'(hourA));
    incA = 1'b0;
    step(3);
    applyStimulus("set_no_day", 8'd0);
    checkOutput(8'(dayCountA - dayBase));
    applyStimulus("set_still", 8'd1);
    checkOutput(8'(settingA));

    // Carry edge in the SET->RUN cycle is judged by SET and dropped.
    setEnA = 1'b0;
    carryA = 1'b1;
    applyStimulus("xit_set_carry", 8'd0);
    applyStimulus("xit_set_state", 8'd0);
    step(3);
    checkOutput(8'(hourA));
    checkOutput(8'(settingA));
    carryA = 1'b0;
    step(2);

    // Carry edge in the RUN->SET cycle is judged by RUN and counts.
    setEnA = 1'b1;
    carryA = 1'b1;
    applyStimulus("xit_run_carry", 8'd1);
    step(3);
    checkOutput(8'(hourA));
    setEnA = 1'b0;
    carryA = 1'b0;
    step(3);

    // Sweep all hours in both display modes.
    for (int k = 0; k < 24; k++) begin
      h     = (1 + k) % 24;
      modeA = 1'b0;
      applyStimulus("sweep_disp12", bcd(disp12(h)));
      applyStimulus("sweep_pm", 8'((h >= 12) ? 1 : 0));
      step(2);
      checkOutput({tensA, onesA});
      checkOutput(8'(pmA));
      modeA = 1'b1;
      applyStimulus("sweep_disp24", bcd(h));
      applyStimulus("sweep_hour", 8'(h));
      step(2);
      checkOutput({tensA, onesA});
      checkOutput(8'(hourA));
      carryA = 1'b1;
      step(2);
      carryA = 1'b0;
      step(2);
    end

    // dutB: held in reset the whole time with carry high and 12-hour mode.
    applyStimulus("b_rst_disp", 8'h05);   checkOutput({tensB, onesB});
    applyStimulus("b_rst_hour", 8'd5);    checkOutput(8'(hourB));
    rstB = 1'b1;
    applyStimulus("b_no_spurious", 8'd5);
    step(3);
    checkOutput(8'(hourB));
    setEnB = 1'b1;
    applyStimulus("b_set_enter", 8'd1);
    step(1);
    checkOutput(8'(settingB));
    incB = 1'b1;
    applyStimulus("b_set_inc", 8'd6);
    step(2);
    checkOutput(8'(hourB));
    incB   = 1'b0;
    carryB = 1'b0;
    step(1);
    rstB   = 1'b0;
    incB   = 1'b1;
    carryB = 1'b1;
    applyStimulus("b_rst_mid_set_hour", 8'd5);
    applyStimulus("b_rst_mid_set_state", 8'd0);
    applyStimulus("b_rst_mid_set_day", 8'd0);
    step(1);
    checkOutput(8'(hourB));
    checkOutput(8'(settingB));
    checkOutput(8'(dayB));
    rstB   = 1'b1;
    setEnB = 1'b0;
    applyStimulus("b_release_levels", 8'd5);
    step(3);
    checkOutput(8'(hourB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cnt_hour.md
CNT_HOUR -- requirements
Module: cnt_hour

Interface
REQ-001 Parameter: INIT_HOUR, 0, hour24 value loaded on reset; legal range 0..23.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset; synchronous and active-low; sampled only on posedge clk.
REQ-004 Port: carry_in  input  1  minute-counter carry level; its rising edge means one hour has elapsed.
REQ-005 Port: mode_24  input  1  display mode; 1 = 24-hour, 0 = 12-hour.
REQ-006 Port: set_en  input  1  level; 1 requests hour-set mode.
REQ-007 Port: set_inc  input  1  set-mode increment request; its rising edge advances the hour.
REQ-008 Port: hour24  output  5  current hour, 0..23.
REQ-009 Port: disp_tens  output  4  BCD tens digit of the displayed hour.
REQ-010 Port: disp_ones  output  4  BCD ones digit of the displayed hour.
REQ-011 Port: pm  output  1  1 when hour24 >= 12, independent of mode_24.
REQ-012 Port: day_clk  output  1  one-cycle carry to the day stage.
REQ-013 Port: setting  output  1  1 while the FSM is in SET.

Function
REQ-014 Edge detect: the block SHALL register carry_in and set_inc into carry_d and inc_d every cycle; carry_edge = carry_in & ~carry_d; inc_edge = set_inc & ~inc_d.
REQ-015 FSM states SHALL be RUN and SET; RUN->SET when set_en=1; SET->RUN when set_en=0; each transition takes effect on the next posedge.
REQ-016 In RUN, a carry_edge SHALL advance hour24 by 1 on the same posedge; inc_edge is ignored.
REQ-017 RUN wrap: on a carry_edge with hour24=23, hour24 SHALL become 0 and day_clk SHALL be 1 for exactly the following cycle.
REQ-018 day_clk SHALL be 0 in every other cycle, including every cycle spent in SET.
REQ-019 In SET, an inc_edge SHALL advance hour24 by 1, wrapping 23->0 without asserting day_clk.
REQ-020 In SET, carry_edge SHALL be discarded, with no deferred increment.
REQ-021 If carry_edge and inc_edge coincide in SET, exactly one increment SHALL occur, from inc_edge.
REQ-022 Edges arriving in the cycle the FSM changes state SHALL be handled by the current-state rules, not the next-state rules.
REQ-023 Because of REQ-014, a level held high on carry_in or set_inc SHALL produce exactly one increment.
REQ-024 24-hour display (mode_24=1): disp_tens/disp_ones SHALL be the BCD of hour24, 00..23.
REQ-025 12-hour display (mode_24=0): hour24 0 and 12 SHALL display 12; 1..11 SHALL display 1..11; 13..23 SHALL display 1..11.
REQ-026 The display outputs SHALL be registered, lagging hour24 and mode_24 by one cycle.
REQ-027 A mode_24 change SHALL alter only the display outputs; hour24 and pm are unaffected.
REQ-028 hour24 SHALL never hold a value above 23.

Reset
REQ-029 When rst=0 at a posedge, the block SHALL load: hour24=INIT_HOUR, FSM=RUN, day_clk=0, setting=0, and pm per INIT_HOUR.
REQ-030 During reset, the display outputs SHALL load the 24-hour BCD of INIT_HOUR.
REQ-031 During reset, carry_d SHALL load carry_in and inc_d SHALL load set_inc, so no spurious edge fires on the first cycle after release.
REQ-032 Reset asserted mid-SET or in the same cycle as a carry_edge SHALL override all other activity, with no increment and no day_clk.

Verification
REQ-033 Reset with INIT_HOUR=0, then 24 carry_in pulses (high 30 cycles, low 30 cycles) -> hour24 steps 0..23 then 0; day_clk high for exactly one cycle, once.
REQ-034 Drive carry_in high for 100 cycles -> exactly one increment.
REQ-035 set_en=1, then 3 set_inc pulses with concurrent carry pulses -> hour24 increases by exactly 3, setting=1, day_clk stays 0.
REQ-036 In SET with hour24=23, one inc_edge -> hour24=0 and day_clk=0.
REQ-037 Sweep hour24 0..23 with mode_24=0 -> display 12,1..11,12,1..11; pm=0 for hours 0..11 and pm=1 for 12..23.
REQ-038 Release reset with carry_in=1 and INIT_HOUR=5 -> hour24 stays 5; assert rst=0 mid-SET -> hour24=5, setting=0 next cycle.
